// File: rtl/anti_theft_fsm_multi.sv
// Vehicle anti-theft controller for NUM_DOORS door sensors, with an internal 1 Hz countdown timer,
// run-time programmable delays, trigger-door logging and a saturating alarm counter.
module anti_theft_fsm_multi #(
    parameter int NUM_DOORS    = 4,
    parameter int DRIVER_IDX   = 0,
    parameter int TW           = 4,
    parameter int T_ARM_DEF    = 6,
    parameter int T_DRV_DEF    = 8,
    parameter int T_PASS_DEF   = 15,
    parameter int T_ALARM_DEF  = 10,
    parameter int BLINK_PERIOD = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ignition,
    input  logic [NUM_DOORS-1:0]         door,
    input  logic                         reprogram,
    input  logic                         one_hz_enable,
    input  logic                         prog_we,
    input  logic [1:0]                   prog_sel,
    input  logic [TW-1:0]                prog_val,
    output logic                         status,
    output logic                         siren,
    output logic [2:0]                   state,
    output logic [TW-1:0]                time_left,
    output logic [$clog2(NUM_DOORS)-1:0] trig_door,
    output logic [7:0]                   alarm_count
);

    localparam int DW = $clog2(NUM_DOORS);
    localparam int BW = $clog2(BLINK_PERIOD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        COUNTDOWN  = 3'd1,
        ALARM      = 3'd2,
        ALARM_HOLD = 3'd3,
        DISARMED   = 3'd4,
        WAIT_OPEN  = 3'd5,
        WAIT_CLOSE = 3'd6,
        ARM_DELAY  = 3'd7
    } state_t;

    // Lowest-index open door; scanning downwards lets the lowest index win.
    function automatic logic [DW-1:0] lowest_open(input logic [NUM_DOORS-1:0] d);
        logic [DW-1:0] idx;
        idx = {DW{1'b0}};
        for (int i = NUM_DOORS - 1; i >= 0; i--) begin
            if (d[i]) begin
                idx = DW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic is_timed(input state_t s);
        return (s == COUNTDOWN) || (s == ALARM_HOLD) || (s == ARM_DELAY);
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   timer_nxt_s;
    logic [BW-1:0]   blink_r;
    logic [BW-1:0]   blink_nxt_s;
    logic [TW-1:0]   t_arm_r;
    logic [TW-1:0]   t_drv_r;
    logic [TW-1:0]   t_pass_r;
    logic [TW-1:0]   t_alarm_r;
    logic [DW-1:0]   trig_r;
    logic [7:0]      alarm_cnt_r;
    logic            status_r;
    logic            siren_r;
    logic            status_nxt_s;
    logic            siren_nxt_s;
    logic            any_door_s;
    logic            drv_door_s;
    logic            expired_s;
    logic            load_s;
    logic [TW-1:0]   load_val_s;
    logic            alarm_inc_s;
    logic            latch_trig_s;

    assign any_door_s = |door;
    assign drv_door_s = door[DRIVER_IDX];
    assign expired_s  = (timer_r == {TW{1'b0}});

    // Next-state decode plus the side effects that belong to each transition.
    always_comb begin
        state_nxt_s  = state_r;
        load_s       = 1'b0;
        load_val_s   = {TW{1'b0}};
        alarm_inc_s  = 1'b0;
        latch_trig_s = 1'b0;
        case (state_r)
            ARMED: begin
                if (any_door_s) begin
                    state_nxt_s  = COUNTDOWN;
                    load_s       = 1'b1;
                    load_val_s   = drv_door_s ? t_drv_r : t_pass_r;
                    latch_trig_s = 1'b1;
                end else if (ignition) begin
                    state_nxt_s = DISARMED;
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            COUNTDOWN: begin
                if (expired_s) begin
                    state_nxt_s = ALARM;
                    alarm_inc_s = 1'b1;
                end else if (reprogram) begin
                    state_nxt_s = ARMED;
                end else if (ignition) begin
                    state_nxt_s = DISARMED;
                end else begin
                    state_nxt_s = COUNTDOWN;
                end
            end
            ALARM: begin
                if (reprogram) begin
                    state_nxt_s = ARMED;
                end else if (!any_door_s) begin
                    state_nxt_s = ALARM_HOLD;
                    load_s      = 1'b1;
                    load_val_s  = t_alarm_r;
                end else begin
                    state_nxt_s = ALARM;
                end
            end
            ALARM_HOLD: begin
                if (any_door_s) begin
                    state_nxt_s = ALARM;
                end else if (expired_s || reprogram) begin
                    state_nxt_s = ARMED;
                end else if (ignition) begin
                    state_nxt_s = DISARMED;
                end else begin
                    state_nxt_s = ALARM_HOLD;
                end
            end
            DISARMED: begin
                if (reprogram) begin
                    state_nxt_s = ARMED;
                end else if (!ignition) begin
                    state_nxt_s = WAIT_OPEN;
                end else begin
                    state_nxt_s = DISARMED;
                end
            end
            WAIT_OPEN: begin
                if (reprogram) begin
                    state_nxt_s = ARMED;
                end else if (ignition) begin
                    state_nxt_s = DISARMED;
                end else if (drv_door_s) begin
                    state_nxt_s = WAIT_CLOSE;
                end else begin
                    state_nxt_s = WAIT_OPEN;
                end
            end
            WAIT_CLOSE: begin
                if (ignition) begin
                    state_nxt_s = DISARMED;
                end else if (!drv_door_s) begin
                    state_nxt_s = ARM_DELAY;
                    load_s      = 1'b1;
                    load_val_s  = t_arm_r;
                end else begin
                    state_nxt_s = WAIT_CLOSE;
                end
            end
            ARM_DELAY: begin
                if (ignition) begin
                    state_nxt_s = DISARMED;
                end else if (drv_door_s) begin
                    state_nxt_s = WAIT_CLOSE;
                end else if (expired_s || reprogram) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = ARM_DELAY;
                end
            end
            default: begin
                state_nxt_s = ARMED;
            end
        endcase
    end

    // Timer: load on entry to a timed state, count down while staying, zero elsewhere.
    always_comb begin
        timer_nxt_s = {TW{1'b0}};
        if (load_s) begin
            timer_nxt_s = load_val_s;
        end else if (is_timed(state_nxt_s) && (state_nxt_s == state_r)) begin
            if (one_hz_enable && !expired_s) begin
                timer_nxt_s = timer_r - {{(TW-1){1'b0}}, 1'b1};
            end else begin
                timer_nxt_s = timer_r;
            end
        end else begin
            timer_nxt_s = {TW{1'b0}};
        end
    end

    // Blink counter only runs while remaining in ARMED; entry or any other state clears it.
    always_comb begin
        blink_nxt_s = {BW{1'b0}};
        if ((state_r == ARMED) && (state_nxt_s == ARMED)) begin
            if (one_hz_enable) begin
                blink_nxt_s = (blink_r == BLINK_LAST) ? {BW{1'b0}} : blink_r + {{(BW-1){1'b0}}, 1'b1};
            end else begin
                blink_nxt_s = blink_r;
            end
        end else begin
            blink_nxt_s = {BW{1'b0}};
        end
    end

    // Moore outputs decoded from the next state so the registered copies track state_r exactly.
    always_comb begin
        status_nxt_s = 1'b0;
        siren_nxt_s  = 1'b0;
        case (state_nxt_s)
            ARMED: begin
                status_nxt_s = (blink_nxt_s == BLINK_LAST);
                siren_nxt_s  = 1'b0;
            end
            COUNTDOWN: begin
                status_nxt_s = 1'b1;
                siren_nxt_s  = 1'b0;
            end
            ALARM, ALARM_HOLD: begin
                status_nxt_s = 1'b1;
                siren_nxt_s  = 1'b1;
            end
            default: begin
                status_nxt_s = 1'b0;
                siren_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, timer, blink, trigger log, alarm counter and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ARMED;
            timer_r     <= {TW{1'b0}};
            blink_r     <= {BW{1'b0}};
            trig_r      <= {DW{1'b0}};
            alarm_cnt_r <= 8'd0;
            status_r    <= 1'b0;
            siren_r     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            timer_r  <= timer_nxt_s;
            blink_r  <= blink_nxt_s;
            status_r <= status_nxt_s;
            siren_r  <= siren_nxt_s;
            if (latch_trig_s) begin
                trig_r <= lowest_open(door);
            end
            if (alarm_inc_s && (alarm_cnt_r != 8'd255)) begin
                alarm_cnt_r <= alarm_cnt_r + 8'd1;
            end
        end
    end

    // Programmable time registers; a zero write is dropped so a delay can never be disabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            t_arm_r   <= TW'(T_ARM_DEF);
            t_drv_r   <= TW'(T_DRV_DEF);
            t_pass_r  <= TW'(T_PASS_DEF);
            t_alarm_r <= TW'(T_ALARM_DEF);
        end else if (prog_we && (prog_val != {TW{1'b0}})) begin
            case (prog_sel)
                2'd0:    t_arm_r   <= prog_val;
                2'd1:    t_drv_r   <= prog_val;
                2'd2:    t_pass_r  <= prog_val;
                2'd3:    t_alarm_r <= prog_val;
                default: t_arm_r   <= t_arm_r;
            endcase
        end
    end

    assign state       = state_r;
    assign time_left   = timer_r;
    assign trig_door   = trig_r;
    assign alarm_count = alarm_cnt_r;
    assign status      = status_r;
    assign siren       = siren_r;

endmodule
